// File: rtl/cpu_axi_pkg.sv
// Shared constants for the CPU sram-like to AXI3 bridge: FSM encoding, default
// read IDs, fixed AXI field values and the latched request record.
package cpu_axi_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_AR   = 3'd1;
   localparam logic [2:0] ST_R    = 3'd2;
   localparam logic [2:0] ST_AW_W = 3'd3;
   localparam logic [2:0] ST_B    = 3'd4;

   localparam logic [3:0] DEF_INST_ARID = 4'd0;
   localparam logic [3:0] DEF_DATA_ARID = 4'd1;

   localparam logic [3:0] AXI_AWID       = 4'd1;
   localparam logic [3:0] AXI_WID        = 4'd1;
   localparam logic [7:0] AXI_LEN        = 8'd0;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_LOCK       = 2'b00;
   localparam logic [3:0] AXI_CACHE      = 4'd0;
   localparam logic [2:0] AXI_PROT       = 3'd0;

   typedef struct packed {
      logic        src_data;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   // sram-like size 0/1/2 maps directly onto AXI 1/2/4 byte transfer sizes
   function automatic logic [2:0] axi_size(input logic [1:0] sz);
      return {1'b0, sz};
   endfunction

endpackage

// File: rtl/cpu_axi_bridge.sv
// Single-outstanding bridge from two sram-like CPU ports (inst, data) to one
// AXI3 master; the data port wins arbitration.
module cpu_axi_bridge
   import cpu_axi_pkg::*;
#(
   parameter logic [3:0] INST_ARID = DEF_INST_ARID,
   parameter logic [3:0] DATA_ARID = DEF_DATA_ARID
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [3:0]  inst_sram_wstrb,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,

   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,

   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,

   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,

   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,

   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,

   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   logic [2:0] state_q, state_d;
   req_t       req_q, req_d;
   logic       aw_done_q, aw_done_d;
   logic       w_done_q, w_done_d;
   logic       in_idle, accept_data, accept_inst;
   logic       ar_hs, r_done, aw_hs, w_hs, b_hs;

   // Only one transaction is ever in flight, so response IDs carry no information.
   logic unused_inputs;
   assign unused_inputs = ^{inst_sram_wr, rid, rresp, bid, bresp};

   assign in_idle     = (state_q == ST_IDLE) && !reset;
   assign accept_data = in_idle && data_sram_req;
   assign accept_inst = in_idle && !data_sram_req && inst_sram_req;

   assign data_sram_addr_ok = accept_data;
   assign inst_sram_addr_ok = accept_inst;

   assign arvalid = !reset && (state_q == ST_AR);
   assign rready  = !reset && (state_q == ST_R);
   assign awvalid = !reset && (state_q == ST_AW_W) && !aw_done_q;
   assign wvalid  = !reset && (state_q == ST_AW_W) && !w_done_q;
   assign bready  = !reset && (state_q == ST_B);

   assign ar_hs  = arvalid && arready;
   assign r_done = rvalid && rready && rlast;
   assign aw_hs  = awvalid && awready;
   assign w_hs   = wvalid && wready;
   assign b_hs   = bvalid && bready;

   assign inst_sram_data_ok = r_done && !req_q.src_data;
   assign data_sram_data_ok = (r_done && req_q.src_data) || b_hs;
   assign inst_sram_rdata   = inst_sram_data_ok ? rdata : 32'd0;
   assign data_sram_rdata   = (r_done && req_q.src_data) ? rdata : 32'd0;

   assign arid    = req_q.src_data ? DATA_ARID : INST_ARID;
   assign araddr  = req_q.addr;
   assign arlen   = AXI_LEN;
   assign arsize  = axi_size(req_q.size);
   assign arburst = AXI_BURST_INCR;
   assign arlock  = AXI_LOCK;
   assign arcache = AXI_CACHE;
   assign arprot  = AXI_PROT;

   assign awid    = AXI_AWID;
   assign awaddr  = req_q.addr;
   assign awlen   = AXI_LEN;
   assign awsize  = axi_size(req_q.size);
   assign awburst = AXI_BURST_INCR;
   assign awlock  = AXI_LOCK;
   assign awcache = AXI_CACHE;
   assign awprot  = AXI_PROT;

   assign wid   = AXI_WID;
   assign wdata = req_q.wdata;
   assign wstrb = req_q.wstrb;
   assign wlast = 1'b1;

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         ST_IDLE: begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (accept_data) begin
               req_d.src_data = 1'b1;
               req_d.size     = data_sram_size;
               req_d.wstrb    = data_sram_wstrb;
               req_d.addr     = data_sram_addr;
               req_d.wdata    = data_sram_wdata;
               state_d        = data_sram_wr ? ST_AW_W : ST_AR;
            end else if (accept_inst) begin
               req_d.src_data = 1'b0;
               req_d.size     = inst_sram_size;
               req_d.wstrb    = inst_sram_wstrb;
               req_d.addr     = inst_sram_addr;
               req_d.wdata    = inst_sram_wdata;
               state_d        = ST_AR;
            end
         end
         ST_AR: if (ar_hs) state_d = ST_R;
         ST_R:  if (r_done) state_d = ST_IDLE;
         ST_AW_W: begin
            // AW and W complete independently; either may finish first or both together.
            aw_done_d = aw_done_q || aw_hs;
            w_done_d  = w_done_q || w_hs;
            if (aw_done_d && w_done_d) state_d = ST_B;
         end
         ST_B:  if (b_hs) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   always_ff @(posedge clk) begin
      req_q <= req_d;
   end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: inst/data reads, arbitration, stores,
// back-pressure and reset mid-transaction, all with hand-computed expectations.
module tb_cpu_axi_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_sram_req, inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr, inst_sram_wdata;
   logic        inst_sram_addr_ok, inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_req, data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr, data_sram_wdata;
   logic        data_sram_addr_ok, data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic [3:0]  arid, awid, wid, rid, bid;
   logic [31:0] araddr, awaddr, wdata, rdata;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize, arprot, awprot;
   logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
   logic [3:0]  arcache, awcache, wstrb;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   int checks = 0;
   int failures = 0;

   cpu_axi_bridge dut (
      .clk(clk), .reset(reset),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
      .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata(inst_sram_rdata),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata(data_sram_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_wstrb = 0;
      inst_sram_addr = 0; inst_sram_wdata = 0;
      data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
      data_sram_addr = 0; data_sram_wdata = 0;
      arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
      awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

      // Reset state, with requests pending that must not be acknowledged
      step(); step();
      inst_sram_req = 1; data_sram_req = 1;
      mid();
      chk("rst_arvalid", 32'(arvalid), 0);
      chk("rst_awvalid", 32'(awvalid), 0);
      chk("rst_wvalid", 32'(wvalid), 0);
      chk("rst_rready", 32'(rready), 0);
      chk("rst_bready", 32'(bready), 0);
      chk("rst_inst_addr_ok", 32'(inst_sram_addr_ok), 0);
      chk("rst_data_addr_ok", 32'(data_sram_addr_ok), 0);
      chk("rst_inst_data_ok", 32'(inst_sram_data_ok), 0);
      chk("rst_data_data_ok", 32'(data_sram_data_ok), 0);
      chk("rst_inst_rdata", inst_sram_rdata, 0);
      chk("rst_data_rdata", data_sram_rdata, 0);
      step();
      reset = 0; inst_sram_req = 0; data_sram_req = 0;

      // Instruction read, wr=1 on the inst side still behaves as a read
      inst_sram_req = 1; inst_sram_wr = 1; inst_sram_addr = 32'h1c000000; inst_sram_size = 2;
      mid();
      chk("t1_inst_addr_ok", 32'(inst_sram_addr_ok), 1);
      chk("t1_data_addr_ok", 32'(data_sram_addr_ok), 0);
      step();
      inst_sram_req = 0; inst_sram_wr = 0; arready = 1;
      mid();
      chk("t1_arvalid", 32'(arvalid), 1);
      chk("t1_arid", 32'(arid), 0);
      chk("t1_araddr", araddr, 32'h1c000000);
      chk("t1_arsize", 32'(arsize), 2);
      chk("t1_awvalid", 32'(awvalid), 0);
      chk("t1_addr_ok_once", 32'(inst_sram_addr_ok), 0);
      step();
      arready = 0;
      mid();
      chk("t1_rready", 32'(rready), 1);
      chk("t1_arvalid_drop", 32'(arvalid), 0);
      chk("t1_no_early_data_ok", 32'(inst_sram_data_ok), 0);
      rvalid = 1; rlast = 1; rdata = 32'h02800c04;
      #1;
      chk("t1_inst_data_ok", 32'(inst_sram_data_ok), 1);
      chk("t1_inst_rdata", inst_sram_rdata, 32'h02800c04);
      chk("t1_data_data_ok", 32'(data_sram_data_ok), 0);
      step();
      rvalid = 0; rlast = 0;
      mid();
      chk("t1_data_ok_pulse", 32'(inst_sram_data_ok), 0);
      chk("t1_rready_idle", 32'(rready), 0);
      step();

      // Simultaneous inst and data reads: data goes first
      data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1c002000; data_sram_size = 2;
      inst_sram_req = 1; inst_sram_addr = 32'h1c000010; inst_sram_size = 2;
      mid();
      chk("t2_data_addr_ok", 32'(data_sram_addr_ok), 1);
      chk("t2_inst_addr_ok", 32'(inst_sram_addr_ok), 0);
      step();
      data_sram_req = 0; arready = 1;
      mid();
      chk("t2_arid_data", 32'(arid), 1);
      chk("t2_araddr", araddr, 32'h1c002000);
      chk("t2_inst_wait_ar", 32'(inst_sram_addr_ok), 0);
      step();
      arready = 0;
      mid();
      chk("t2_inst_wait_r", 32'(inst_sram_addr_ok), 0);
      rvalid = 1; rlast = 1; rdata = 32'h11223344;
      #1;
      chk("t2_data_data_ok", 32'(data_sram_data_ok), 1);
      chk("t2_data_rdata", data_sram_rdata, 32'h11223344);
      chk("t2_inst_data_ok", 32'(inst_sram_data_ok), 0);
      step();
      rvalid = 0; rlast = 0;
      mid();
      chk("t2_inst_addr_ok_after", 32'(inst_sram_addr_ok), 1);
      step();
      inst_sram_req = 0; arready = 1;
      mid();
      chk("t2_arid_inst", 32'(arid), 0);
      chk("t2_araddr_inst", araddr, 32'h1c000010);
      step();
      arready = 0;
      mid();
      rvalid = 1; rlast = 1; rdata = 32'h55667788;
      #1;
      chk("t2_inst_data_ok", 32'(inst_sram_data_ok), 1);
      chk("t2_inst_rdata", inst_sram_rdata, 32'h55667788);
      step();
      rvalid = 0; rlast = 0;

      // Store with awready delayed, wready immediate
      data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1c001000; data_sram_size = 2;
      data_sram_wstrb = 4'hf; data_sram_wdata = 32'hdeadbeef;
      mid();
      chk("t3_data_addr_ok", 32'(data_sram_addr_ok), 1);
      step();
      data_sram_req = 0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0; wready = 1;
      mid();
      chk("t3_awvalid_c1", 32'(awvalid), 1);
      chk("t3_wvalid_c1", 32'(wvalid), 1);
      chk("t3_awaddr", awaddr, 32'h1c001000);
      chk("t3_awsize", 32'(awsize), 2);
      chk("t3_wdata", wdata, 32'hdeadbeef);
      chk("t3_wstrb", 32'(wstrb), 32'hf);
      chk("t3_awid", 32'(awid), 1);
      chk("t3_wid", 32'(wid), 1);
      chk("t3_wlast", 32'(wlast), 1);
      chk("t3_arvalid", 32'(arvalid), 0);
      step();
      wready = 0;
      mid();
      chk("t3_wvalid_c2", 32'(wvalid), 0);
      chk("t3_awvalid_c2", 32'(awvalid), 1);
      step();
      awready = 1;
      mid();
      chk("t3_awvalid_c3", 32'(awvalid), 1);
      chk("t3_awaddr_hold", awaddr, 32'h1c001000);
      step();
      awready = 0;
      mid();
      chk("t3_awvalid_b", 32'(awvalid), 0);
      chk("t3_bready", 32'(bready), 1);
      chk("t3_no_early_ok", 32'(data_sram_data_ok), 0);
      bvalid = 1;
      #1;
      chk("t3_data_ok", 32'(data_sram_data_ok), 1);
      chk("t3_inst_data_ok", 32'(inst_sram_data_ok), 0);
      step();
      bvalid = 0;
      mid();
      chk("t3_bready_idle", 32'(bready), 0);
      chk("t3_data_ok_pulse", 32'(data_sram_data_ok), 0);
      step();

      // Store with AW and W completing in the same cycle
      data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1c001004; data_sram_size = 1;
      data_sram_wstrb = 4'h3; data_sram_wdata = 32'h12345678;
      mid();
      chk("t4_data_addr_ok", 32'(data_sram_addr_ok), 1);
      step();
      data_sram_req = 0; awready = 1; wready = 1;
      mid();
      chk("t4_awvalid", 32'(awvalid), 1);
      chk("t4_wvalid", 32'(wvalid), 1);
      chk("t4_awsize", 32'(awsize), 1);
      chk("t4_wstrb", 32'(wstrb), 3);
      step();
      awready = 0; wready = 0;
      mid();
      chk("t4_bready", 32'(bready), 1);
      chk("t4_awvalid_b", 32'(awvalid), 0);
      chk("t4_wvalid_b", 32'(wvalid), 0);
      bvalid = 1;
      #1;
      chk("t4_data_ok", 32'(data_sram_data_ok), 1);
      step();
      bvalid = 0; data_sram_wr = 0;

      // Byte read under AR back-pressure; request held high with a changing address
      data_sram_req = 1; data_sram_size = 0; data_sram_addr = 32'h1c000003;
      mid();
      chk("t5_data_addr_ok", 32'(data_sram_addr_ok), 1);
      step();
      data_sram_addr = 32'h1c00ff00; data_sram_size = 2;
      for (int i = 0; i < 5; i++) begin
         mid();
         chk("t5_arvalid_hold", 32'(arvalid), 1);
         chk("t5_araddr_stable", araddr, 32'h1c000003);
         chk("t5_arsize_byte", 32'(arsize), 0);
         chk("t5_no_second_addr_ok", 32'(data_sram_addr_ok), 0);
         step();
      end
      data_sram_req = 0; arready = 1;
      mid();
      chk("t5_arvalid_final", 32'(arvalid), 1);
      step();
      arready = 0;
      mid();
      chk("t5_rready", 32'(rready), 1);

      // Reset while in R, then a late response must be ignored
      step();
      reset = 1;
      step();
      reset = 0; rvalid = 1; rlast = 1; rdata = 32'hcafef00d;
      mid();
      chk("t6_rready", 32'(rready), 0);
      chk("t6_arvalid", 32'(arvalid), 0);
      chk("t6_awvalid", 32'(awvalid), 0);
      chk("t6_wvalid", 32'(wvalid), 0);
      chk("t6_bready", 32'(bready), 0);
      chk("t6_data_data_ok", 32'(data_sram_data_ok), 0);
      chk("t6_inst_data_ok", 32'(inst_sram_data_ok), 0);
      chk("t6_data_rdata", data_sram_rdata, 0);
      step();
      rvalid = 0; rlast = 0;
      mid();
      chk("t6_late_data_ok", 32'(data_sram_data_ok), 0);
      chk("t6_arvalid_idle", 32'(arvalid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
